rob_buffer: RTL and testbench

- In-order reorder buffer between the rename stage and the retirement/free-list logic.
- Allocates one entry per cycle for each renamed instruction and returns its rob tag.
- Marks entries complete from the ALU, memory and branch FU writeback ports.
- Retires the oldest completed entry each cycle and flushes younger entries on a branch mispredict.

---
 rtl/rob_buffer.sv | 165 ++++++++++++++++
 tb/tb_rob_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_buffer.sv
// rob_buffer: in-order reorder buffer between rename and retirement.
//
// Ports
//   clk, reset_n                     clock, synchronous active-low reset
//   alloc_valid/ready, alloc_pc,
//   alloc_pd_new/old, alloc_tag      rename allocation; tag = tail pointer
//   {alu,mem,br}_done/_tag           FU writeback completion strobes
//   mispredict, mispredict_tag       flush every entry younger than the tag
//   retire_valid/tag/pc/pd_new/old   head entry retiring this cycle
//   full, empty, count               occupancy, derived from count only
//
// Each slot is a rob_entry instance. The top computes per-slot write,
// complete-set and clear strobes; slots only hold state.

module rob_entry #(
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              set_cmp,
  input  logic              clr,
  input  logic [31:0]       w_pc,
  input  logic [PREG_W-1:0] w_pd_new,
  input  logic [PREG_W-1:0] w_pd_old,
  output logic              valid,
  output logic              complete,
  output logic [31:0]       pc,
  output logic [PREG_W-1:0] pd_new,
  output logic [PREG_W-1:0] pd_old
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      complete <= 1'b0;
    end else if (we) begin
      valid    <= 1'b1;
      complete <= 1'b0;
    end else if (clr) begin
      // Flush beats a same-cycle completion, so strobes to flushed tags drop.
      valid    <= 1'b0;
      complete <= 1'b0;
    end else if (set_cmp) begin
      complete <= 1'b1;
    end
  end

  // Payload needs no reset; it is only observed while valid is set.
  always_ff @(posedge clk) begin
    if (we) begin
      pc     <= w_pc;
      pd_new <= w_pd_new;
      pd_old <= w_pd_old;
    end
  end

endmodule

module rob_buffer #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [31:0]       alloc_pc,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              alu_done,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic              mem_done,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic              br_done,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic [31:0]       retire_pc,
  output logic [PREG_W-1:0] retire_pd_new,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count
);

  logic [TAG_W-1:0]              head, tail;
  logic [DEPTH-1:0]              e_valid, e_cmp;
  logic [DEPTH-1:0][31:0]        e_pc;
  logic [DEPTH-1:0][PREG_W-1:0]  e_pd_new, e_pd_old;
  logic                          accept;
  logic [TAG_W-1:0]              age_m;

  // Outputs are held at their reset values while reset_n is low so nothing
  // leaks out of stale state before the reset edge.
  assign full         = reset_n && (count == (TAG_W+1)'(DEPTH));
  assign empty        = !reset_n || (count == '0);
  assign alloc_ready  = reset_n && !full && !mispredict;
  assign alloc_tag    = reset_n ? tail : '0;
  assign accept       = alloc_valid && alloc_ready;

  assign retire_valid  = reset_n && e_valid[head] && e_cmp[head];
  assign retire_tag    = head;
  assign retire_pc     = e_pc[head];
  assign retire_pd_new = e_pd_new[head];
  assign retire_pd_old = e_pd_old[head];

  // Age relative to head; modulo wrap falls out of the TAG_W-bit subtract.
  assign age_m = mispredict_tag - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [TAG_W-1:0] IDX = TAG_W'(i);
    logic [TAG_W-1:0] age;
    logic flush, hit, set_cmp, clr, we;

    assign age     = IDX - head;
    assign flush   = mispredict && (age > age_m);
    assign hit     = (alu_done && alu_tag == IDX) ||
                     (mem_done && mem_tag == IDX) ||
                     (br_done  && br_tag  == IDX);
    assign set_cmp = e_valid[i] && hit && !flush;
    assign clr     = flush || (retire_valid && head == IDX);
    // Alloc never targets the head while it retires: head==tail only when
    // empty (nothing to retire) or full (alloc refused).
    assign we      = accept && tail == IDX;

    rob_entry #(.PREG_W(PREG_W)) u_ent (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .set_cmp  (set_cmp),
      .clr      (clr),
      .w_pc     (alloc_pc),
      .w_pd_new (alloc_pd_new),
      .w_pd_old (alloc_pd_old),
      .valid    (e_valid[i]),
      .complete (e_cmp[i]),
      .pc       (e_pc[i]),
      .pd_new   (e_pd_new[i]),
      .pd_old   (e_pd_old[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire_valid) head <= head + 1'b1;
      if (mispredict) begin
        tail  <= mispredict_tag + 1'b1;
        count <= (TAG_W+1)'(age_m) + (TAG_W+1)'(1) - (TAG_W+1)'(retire_valid);
      end else begin
        if (accept) tail <= tail + 1'b1;
        count <= count + (TAG_W+1)'(accept) - (TAG_W+1)'(retire_valid);
      end
    end
  end

endmodule

// File: tb/tb_rob_buffer.sv
module tb_rob_buffer;
  localparam int TAG_W = 5, PREG_W = 7;

  logic clk = 1'b0, reset_n = 1'b0;
  logic alloc_valid, alloc_ready;
  logic [31:0] alloc_pc;
  logic [PREG_W-1:0] alloc_pd_new, alloc_pd_old;
  logic [TAG_W-1:0] alloc_tag;
  logic alu_done, mem_done, br_done, mispredict;
  logic [TAG_W-1:0] alu_tag, mem_tag, br_tag, mispredict_tag;
  logic retire_valid;
  logic [TAG_W-1:0] retire_tag;
  logic [31:0] retire_pc;
  logic [PREG_W-1:0] retire_pd_new, retire_pd_old;
  logic full, empty;
  logic [TAG_W:0] count;

  int checks = 0, failures = 0;

  rob_buffer #(.DEPTH(32), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old), .alloc_tag(alloc_tag),
    .alu_done(alu_done), .alu_tag(alu_tag), .mem_done(mem_done), .mem_tag(mem_tag),
    .br_done(br_done), .br_tag(br_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_pc(retire_pc),
    .retire_pd_new(retire_pd_new), .retire_pd_old(retire_pd_old),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_pd_new = '0; alloc_pd_old = '0;
    alu_done = 0; alu_tag = '0; mem_done = 0; mem_tag = '0;
    br_done = 0; br_tag = '0; mispredict = 0; mispredict_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset_n = 0; tick(); tick(); reset_n = 1; #1;
  endtask

  task automatic alloc_n(input int n, input logic [31:0] pc0);
    for (int k = 0; k < n; k++) begin
      alloc_valid = 1; alloc_pc = pc0 + 32'(4*k);
      alloc_pd_new = PREG_W'(32'h20 + k); alloc_pd_old = PREG_W'(32'h40 + k);
      tick();
    end
    alloc_valid = 0; #1;
  endtask

  task automatic test_reset();
    idle_inputs(); reset_n = 0; alloc_valid = 1; #1;
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low got=%b exp=0", alloc_ready); end
    tick(); tick(); alloc_valid = 0; #1;
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (count !== 6'd0 || alloc_tag !== 5'd0) begin failures++; $display("FAIL rst_count_tag got=%0d/%0d exp 0/0", count, alloc_tag); end
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL rst_retire got=%b exp=0", retire_valid); end
    reset_n = 1; #1;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", alloc_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      alloc_valid = 1; alloc_pc = 32'h1000 + 32'(4*k); #1;
      checks++; if (alloc_tag !== 5'(k) || alloc_ready !== 1'b1 || retire_valid !== 1'b0) begin
        failures++; $display("FAIL fill_k%0d got tag=%0d rdy=%b rv=%b exp tag=%0d rdy=1 rv=0", k, alloc_tag, alloc_ready, retire_valid, k);
      end
      tick();
    end
    #1;
    checks++; if (full !== 1'b1 || count !== 6'd32 || alloc_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got full=%b cnt=%0d rdy=%b exp 1/32/0", full, count, alloc_ready);
    end
    tick(); alloc_valid = 0; #1;
    checks++; if (count !== 6'd32 || retire_valid !== 1'b0) begin failures++; $display("FAIL fill_33rd got cnt=%0d rv=%b exp 32/0", count, retire_valid); end
  endtask

  task automatic test_retire_order();
    do_reset();
    alloc_n(4, 32'h2000);
    alu_done = 1; alu_tag = 5'd2; tick(); idle_inputs(); #1;
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL ord_c2 got rv=%b exp=0", retire_valid); end
    mem_done = 1; mem_tag = 5'd1; tick(); idle_inputs(); #1;
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL ord_c1 got rv=%b exp=0", retire_valid); end
    br_done = 1; br_tag = 5'd3; tick(); idle_inputs(); #1;
    checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL ord_c3 got rv=%b exp=0", retire_valid); end
    alu_done = 1; alu_tag = 5'd0; tick(); idle_inputs(); #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (retire_valid !== 1'b1 || retire_tag !== 5'(k) || retire_pd_old !== 7'(8'h40 + k) ||
                    retire_pd_new !== 7'(8'h20 + k) || retire_pc !== 32'h2000 + 32'(4*k)) begin
        failures++; $display("FAIL ord_ret%0d got rv=%b tag=%0d old=%0h new=%0h pc=%0h exp rv=1 tag=%0d old=%0h", k, retire_valid, retire_tag, retire_pd_old, retire_pd_new, retire_pc, k, 8'h40 + k);
      end
      tick();
    end
    checks++; if (retire_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL ord_done got rv=%b empty=%b exp 0/1", retire_valid, empty); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(10, 32'h3000);
    mispredict = 1; mispredict_tag = 5'd4; br_done = 1; br_tag = 5'd4; alloc_valid = 1; #1;
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL mp_block got rdy=%b exp=0", alloc_ready); end
    tick(); idle_inputs(); #1;
    checks++; if (count !== 6'd5 || alloc_tag !== 5'd5) begin failures++; $display("FAIL mp_count got cnt=%0d tag=%0d exp 5/5", count, alloc_tag); end
    alu_done = 1; alu_tag = 5'd7; tick(); idle_inputs(); #1;
    alloc_n(3, 32'h4000);  // tags 5,6,7 re-allocated fresh
    checks++; if (count !== 6'd8) begin failures++; $display("FAIL mp_realloc got cnt=%0d exp=8", count); end
    alu_done = 1; alu_tag = 5'd0; mem_done = 1; mem_tag = 5'd1; br_done = 1; br_tag = 5'd2;
    tick(); idle_inputs(); #1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin alu_done = 1; alu_tag = 5'd3; mem_done = 1; mem_tag = 5'd5; br_done = 1; br_tag = 5'd6; #1; end
      checks++; if (retire_valid !== 1'b1 || retire_tag !== 5'(k)) begin
        failures++; $display("FAIL mp_ret%0d got rv=%b tag=%0d exp rv=1 tag=%0d", k, retire_valid, retire_tag, k);
      end
      tick(); idle_inputs(); #1;
    end
    // Tag 7's early strobe hit an invalid slot, so it must not retire.
    checks++; if (retire_valid !== 1'b0 || retire_tag !== 5'd7 || count !== 6'd1) begin
      failures++; $display("FAIL mp_tag7 got rv=%b tag=%0d cnt=%0d exp 0/7/1", retire_valid, retire_tag, count);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    alloc_n(32, 32'h5000);
    alu_done = 1; alu_tag = 5'd0; tick(); idle_inputs();
    alloc_valid = 1; alloc_pc = 32'h6000; #1;
    checks++; if (alloc_ready !== 1'b0 || retire_valid !== 1'b1 || full !== 1'b1) begin
      failures++; $display("FAIL full_c0 got rdy=%b rv=%b full=%b exp 0/1/1", alloc_ready, retire_valid, full);
    end
    tick();
    checks++; if (count !== 6'd31 || alloc_ready !== 1'b1 || alloc_tag !== 5'd0) begin
      failures++; $display("FAIL full_c1 got cnt=%0d rdy=%b tag=%0d exp 31/1/0", count, alloc_ready, alloc_tag);
    end
    tick(); alloc_valid = 0; #1;
    checks++; if (count !== 6'd32 || full !== 1'b1 || retire_valid !== 1'b0) begin
      failures++; $display("FAIL full_c2 got cnt=%0d full=%b rv=%b exp 32/1/0", count, full, retire_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      alloc_valid = 1; tick(); alloc_valid = 0;
      alu_done = 1; alu_tag = 5'(k); tick(); alu_done = 0;
      tick();
    end
    #1;
    checks++; if (count !== 6'd0 || alloc_tag !== 5'd30) begin failures++; $display("FAIL wrap_pos got cnt=%0d tag=%0d exp 0/30", count, alloc_tag); end
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1; alloc_pc = 32'h7000 + 32'(4*k); #1;
      checks++; if (alloc_tag !== 5'((30 + k) % 32)) begin
        failures++; $display("FAIL wrap_tag%0d got=%0d exp=%0d", k, alloc_tag, (30 + k) % 32);
      end
      tick();
    end
    alloc_valid = 0;
    mispredict = 1; mispredict_tag = 5'd31; alu_done = 1; alu_tag = 5'd0; tick(); idle_inputs(); #1;
    checks++; if (count !== 6'd2 || alloc_tag !== 5'd0) begin failures++; $display("FAIL wrap_mp got cnt=%0d tag=%0d exp 2/0", count, alloc_tag); end
    alu_done = 1; alu_tag = 5'd1; br_done = 1; br_tag = 5'd30; mem_done = 1; mem_tag = 5'd31;
    tick(); idle_inputs(); #1;
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 5'd30 || retire_pc !== 32'h7000) begin
      failures++; $display("FAIL wrap_r30 got rv=%b tag=%0d pc=%0h exp 1/30/7000", retire_valid, retire_tag, retire_pc);
    end
    tick();
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 5'd31) begin failures++; $display("FAIL wrap_r31 got rv=%b tag=%0d exp 1/31", retire_valid, retire_tag); end
    tick();
    checks++; if (retire_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL wrap_end got rv=%b empty=%b exp 0/1", retire_valid, empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(10, 32'h8000);
    alu_done = 1; alu_tag = 5'd0; mem_done = 1; mem_tag = 5'd1; br_done = 1; br_tag = 5'd2;
    tick(); idle_inputs();
    reset_n = 0; #1;
    checks++; if (retire_valid !== 1'b0 || alloc_ready !== 1'b0) begin
      failures++; $display("FAIL rmid_during got rv=%b rdy=%b exp 0/0", retire_valid, alloc_ready);
    end
    tick(); reset_n = 1; #1;
    checks++; if (empty !== 1'b1 || retire_valid !== 1'b0 || alloc_tag !== 5'd0 || count !== 6'd0) begin
      failures++; $display("FAIL rmid_after got empty=%b rv=%b tag=%0d cnt=%0d exp 1/0/0/0", empty, retire_valid, alloc_tag, count);
    end
    tick(); tick();
    checks++; if (retire_valid !== 1'b0 || count !== 6'd0) begin failures++; $display("FAIL rmid_quiet got rv=%b cnt=%0d exp 0/0", retire_valid, count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_retire_order();
    test_mispredict();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
